// File: rtl/line_xfer_engine.sv
// Line transfer engine: turns one whole-line refill or victim writeback from the
// cache arbiter into single-word memory beats and returns the line or a write ack.
module line_xfer_engine #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_write,
  output logic [WORD_W*LINE_WORDS-1:0] resp_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [WORD_W-1:0]            mem_req_wdata,
  input  logic                         mem_rsp_valid,
  input  logic [WORD_W-1:0]            mem_rsp_rdata,
  output logic                         busy
);
  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int BEAT_W     = $clog2(LINE_WORDS);
  localparam int WORD_BYTES = WORD_W / 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              write_q, write_d;
  line_t             line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d;
  line_t             wdata_q, wdata_d;
  logic              last_beat;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    line_base = addr & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

  // Base is line-aligned, so the sum never carries out of the line offset.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [BEAT_W-1:0] beat);
    beat_addr = base + ADDR_W'(beat) * ADDR_W'(WORD_BYTES);
  endfunction

  assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    write_d = write_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SEND;
          beat_d  = '0;
          write_d = req_write;
          base_d  = line_base(req_addr);
          wdata_d = req_wdata;
          if (!req_write) line_d = '0;
        end
      end
      SEND: begin
        if (mem_req_ready) begin
          if (!write_q)       state_d = WAIT;
          else if (last_beat) state_d = DONE;
          else                beat_d  = beat_q + BEAT_W'(1);
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          line_d[beat_q] = mem_rsp_rdata;
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = SEND;
          end
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      write_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      write_q <= write_d;
      line_q  <= line_d;
    end
  end

  // Request payload is only observed through gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mem_req_valid = (state_q == SEND);
  assign mem_req_we    = mem_req_valid && write_q;
  assign mem_req_addr  = mem_req_valid ? beat_addr(base_q, beat_q) : '0;
  assign mem_req_wdata = mem_req_valid ? wdata_q[beat_q] : '0;
  assign resp_valid    = (state_q == DONE);
  assign resp_write    = resp_valid && write_q;
  assign resp_rdata    = (resp_valid && !write_q) ? line_q : '0;

endmodule
